// File: rtl/w_writeback.sv
// Write-back stage: MEM/WB pipeline register, retiring-instruction decode,
// load-data extension and GRF write-port drive, plus a retired-instruction counter.
module w_writeback #(
    parameter int RETIRE_W    = 32,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         M_PC,
    input  logic [31:0]         M_instr,
    input  logic [31:0]         M_ALUResult,
    input  logic [31:0]         M_MemData,
    input  logic                M_valid,
    input  logic                W_stall,
    input  logic                W_flush,
    output logic                W_RegWrite,
    output logic [4:0]          W_RegToWrite,
    output logic [31:0]         W_WriteData,
    output logic [31:0]         W_PC,
    output logic [31:0]         W_instr,
    output logic                W_valid,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam logic [4:0]  LINK_ADDR = 5'(LINK_REG);
    localparam logic [31:0] LINK_ADD  = 32'(LINK_OFFSET);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    logic [31:0]         r_pc;
    logic [31:0]         r_instr;
    logic [31:0]         r_alu;
    logic [31:0]         r_mem;
    logic                r_valid;
    logic [RETIRE_W-1:0] r_retire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc     <= '0;
            r_instr  <= '0;
            r_alu    <= '0;
            r_mem    <= '0;
            r_valid  <= 1'b0;
            r_retire <= '0;
        end else if (W_flush) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_alu   <= '0;
            r_mem   <= '0;
            r_valid <= 1'b0;
        end else if (!W_stall) begin
            r_pc    <= M_PC;
            r_instr <= M_instr;
            r_alu   <= M_ALUResult;
            r_mem   <= M_MemData;
            r_valid <= M_valid;
            if (M_valid)
                r_retire <= r_retire + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_link;
    logic        w_writes;
    logic [4:0]  w_dest;
    logic [31:0] w_data;

    assign w_op   = r_instr[31:26];
    assign w_fn   = r_instr[5:0];
    assign w_rt   = r_instr[20:16];
    assign w_rd   = r_instr[15:11];
    assign w_link = r_pc + LINK_ADD;
    // Little-endian lanes: byte 0 is bits [7:0]; halfword picked by addr bit 1 only.
    assign w_half = r_alu[1] ? r_mem[31:16] : r_mem[15:0];

    always_comb begin
        w_byte = r_mem[7:0];
        case (r_alu[1:0])
            2'd0: w_byte = r_mem[7:0];
            2'd1: w_byte = r_mem[15:8];
            2'd2: w_byte = r_mem[23:16];
            2'd3: w_byte = r_mem[31:24];
            default: w_byte = r_mem[7:0];
        endcase
    end

    always_comb begin
        w_writes = 1'b0;
        w_dest   = 5'd0;
        w_data   = 32'd0;
        case (w_op)
            OP_RTYPE: begin
                if (r_instr != 32'd0 && w_fn != FN_JR) begin
                    w_writes = 1'b1;
                    w_dest   = w_rd;
                    w_data   = (w_fn == FN_JALR) ? w_link : r_alu;
                end
            end
            OP_ORI, OP_LUI, OP_ADDIU: begin
                w_writes = 1'b1;
                w_dest   = w_rt;
                w_data   = r_alu;
            end
            OP_LW: begin
                w_writes = 1'b1;
                w_dest   = w_rt;
                w_data   = r_mem;
            end
            OP_LB, OP_LBU: begin
                w_writes = 1'b1;
                w_dest   = w_rt;
                w_data   = {{24{(w_op == OP_LB) & w_byte[7]}}, w_byte};
            end
            OP_LH, OP_LHU: begin
                w_writes = 1'b1;
                w_dest   = w_rt;
                w_data   = {{16{(w_op == OP_LH) & w_half[15]}}, w_half};
            end
            OP_JAL: begin
                w_writes = 1'b1;
                w_dest   = LINK_ADDR;
                w_data   = w_link;
            end
            default: ;
        endcase
    end

    // Writes to $0 are suppressed and the address/data buses are zeroed when idle.
    assign W_RegWrite   = r_valid & w_writes & (w_dest != 5'd0);
    assign W_RegToWrite = W_RegWrite ? w_dest : 5'd0;
    assign W_WriteData  = W_RegWrite ? w_data : 32'd0;
    assign W_PC         = r_pc;
    assign W_instr      = r_instr;
    assign W_valid      = r_valid;
    assign retire_count = r_retire;

endmodule
